hazard_ctl: RTL
===============

// Module: hazard_ctl
// PURPOSE
//   Pipeline hazard/stall scheduler for the 5-stage MIPS core (IF/ID/EX/ME/WB).
//   Detects load-use hazards, sequences data-memory wait states and collects
//   branch redirects. Drives per-stage stall/flush controls and AnyStall.
//   Sits beside fetch/decode/execute/memory in the core top level.
// PARAMETERS
//   MEM_WAIT  2  extra cycles the data memory needs per load/store (0 = single-cycle)
//   CNT_W     3  width of the wait-state counter; must hold MEM_WAIT
// PORTS
//   clk               in   1   core clock, rising edge
//   reset             in   1   async, active-high
//   Valid_ID          in   1   ID holds a real instruction
//   Rs_ID             in   5   ID source register A
//   Rt_ID             in   5   ID source register B
//   UsesRt_ID         in   1   Rt_ID is a read source (R-type, store, branch)
//   RegWrite_EX       in   1   EX instruction writes the register file
//   MemToReg_EX       in   1   EX instruction is a load
//   WriteReg_EX       in   5   EX destination register
//   MemReq_EX         in   1   EX instruction is a load or store (enters ME next)
//   BranchTaken_EXM1  in   1   registered branch-taken pulse from execute
//   Stall_IF          out  1   hold PC and fetch register
//   Stall_ID          out  1   hold ID pipeline register
//   Flush_ID          out  1   squash ID register (redirect)
//   Flush_EX          out  1   insert bubble into EX register
//   AnyStall          out  1   global freeze of all stages (memory wait)
// BEHAVIOUR
//   - Reset (async): state=IDLE, wait counter=0, pending-redirect=0; all outputs 0.
//   - Outputs are combinational from state + current inputs (same-cycle effect).
//   - States: IDLE, LDUSE, MEMWAIT.
//   - Load-use hit: Valid_ID & RegWrite_EX & MemToReg_EX & WriteReg_EX!=0 &
//     (WriteReg_EX==Rs_ID | (UsesRt_ID & WriteReg_EX==Rt_ID)).
//   - IDLE: hit -> Stall_IF=Stall_ID=Flush_EX=1 this cycle, next=LDUSE.
//     MemReq_EX & MEM_WAIT>0 & no hit -> counter<=MEM_WAIT, next=MEMWAIT.
//   - LDUSE: exactly one bubble; hit is ignored this cycle (load now in ME);
//     MemReq_EX handled as in IDLE; else next=IDLE.
//   - MEMWAIT: AnyStall=Stall_IF=Stall_ID=1; counter decrements each cycle;
//     counter==1 -> next=IDLE (AnyStall deasserts the cycle counter hits 0).
//     Total freeze = MEM_WAIT cycles per memory op; back-to-back ops re-enter.
//   - Priority: MEMWAIT freeze > load-use bubble > redirect flush.
//   - Redirect: BranchTaken_EXM1 with AnyStall=0 -> Flush_ID=1 same cycle.
//     With AnyStall=1 -> pending<=1; Flush_ID=1 on first cycle AnyStall=0,
//     then pending cleared. Branch + load-use same cycle: Flush_ID and
//     Flush_EX both 1, Stall_IF forced 0 (redirect PC must load), next=IDLE.
//   - WriteReg_EX==0 never raises a hazard (r0 hardwired).
//   - Reset mid-MEMWAIT/LDUSE: immediate return to IDLE, pending dropped.
// CONFIGURATION
//   HAZARD_PERF_CNT_EN defined: adds outputs StallCycles (32b, counts cycles with
//     Stall_ID=1) and FlushCount (32b, counts Flush_ID pulses); both reset to 0,
//     saturate at all-ones. Undefined: ports and counters absent, no other change.
// TESTING
//   lw r5 in EX, add r6,r5,r1 in ID -> Stall_IF/Stall_ID/Flush_EX=1 one cycle, then 0.
//   lw r0 in EX, ID reads r0 -> no stall, all outputs 0.
//   MEM_WAIT=2, MemReq_EX pulse in IDLE -> AnyStall=1 for exactly 2 cycles, then 0.
//   BranchTaken_EXM1 during MEMWAIT cycle 1 -> Flush_ID=1 only on first cycle after
//     AnyStall falls, one cycle wide.
//   Branch + load-use hit same cycle -> Flush_ID=1, Flush_EX=1, Stall_IF=0.
//   reset asserted mid-MEMWAIT -> all outputs 0 asynchronously; next MemReq restarts
//     full MEM_WAIT count.

Source files
------------

// File: rtl/hazard_ctl_if.sv
// ============================================================================
//  Module      : hazard_ctl_if
//  Description : Decode/execute hazard sideband and stall/flush controls
//                exchanged between the pipeline and hazard_ctl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctl_if;
    logic       Valid_ID;
    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       UsesRt_ID;
    logic       RegWrite_EX;
    logic       MemToReg_EX;
    logic [4:0] WriteReg_EX;
    logic       MemReq_EX;
    logic       BranchTaken_EXM1;
    logic       Stall_IF;
    logic       Stall_ID;
    logic       Flush_ID;
    logic       Flush_EX;
    logic       AnyStall;

    modport master (
        output Valid_ID, Rs_ID, Rt_ID, UsesRt_ID,
        output RegWrite_EX, MemToReg_EX, WriteReg_EX, MemReq_EX,
        output BranchTaken_EXM1,
        input  Stall_IF, Stall_ID, Flush_ID, Flush_EX, AnyStall
    );

    modport slave (
        input  Valid_ID, Rs_ID, Rt_ID, UsesRt_ID,
        input  RegWrite_EX, MemToReg_EX, WriteReg_EX, MemReq_EX,
        input  BranchTaken_EXM1,
        output Stall_IF, Stall_ID, Flush_ID, Flush_EX, AnyStall
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctl.sv
// ============================================================================
//  Module      : hazard_ctl
//  Description : 5-stage pipeline hazard scheduler: load-use bubbles, data
//                memory wait-state freeze and branch redirect flushes.
//                Optional HAZARD_PERF_CNT_EN adds stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctl #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    hazard_ctl_if.slave      bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      StallCycles,
    output logic [31:0]      FlushCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LDUSE   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    localparam bit             c_WAIT_EN = (MEM_WAIT > 0);
    localparam logic [CNT_W-1:0] c_WAIT_LD = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;

    logic w_hit;
    logic w_redirect;
    logic w_stall_if;
    logic w_stall_id;
    logic w_flush_id;
    logic w_flush_ex;
    logic w_any_stall;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard
    assign w_hit = bus.Valid_ID && bus.RegWrite_EX && bus.MemToReg_EX &&
                   (bus.WriteReg_EX != 5'd0) &&
                   ((bus.WriteReg_EX == bus.Rs_ID) ||
                    (bus.UsesRt_ID && (bus.WriteReg_EX == bus.Rt_ID)));

    assign w_redirect = bus.BranchTaken_EXM1 || r_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_any_stall = 1'b0;

        if (!reset) begin
            case (r_state)
                S_MEMWAIT: begin
                    // Redirects arriving during the freeze are held until it lifts
                    w_any_stall = 1'b1;
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_cnt_nxt   = r_cnt - c_ONE;
                    if (bus.BranchTaken_EXM1) begin
                        w_pend_nxt = 1'b1;
                    end
                    if (r_cnt <= c_ONE) begin
                        w_state_nxt = S_IDLE;
                    end
                end

                S_IDLE, S_LDUSE: begin
                    w_flush_id = w_redirect;
                    w_pend_nxt = 1'b0;
                    if ((r_state == S_IDLE) && w_hit) begin
                        // A taken redirect must still load the new PC
                        w_stall_if  = !w_redirect;
                        w_stall_id  = 1'b1;
                        w_flush_ex  = 1'b1;
                        w_state_nxt = w_redirect ? S_IDLE : S_LDUSE;
                    end else if (bus.MemReq_EX && c_WAIT_EN) begin
                        w_cnt_nxt   = c_WAIT_LD;
                        w_state_nxt = S_MEMWAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.Stall_IF = w_stall_if;
    assign bus.Stall_ID = w_stall_id;
    assign bus.Flush_ID = w_flush_id;
    assign bus.Flush_EX = w_flush_ex;
    assign bus.AnyStall = w_any_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_id && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_id && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

endmodule

`default_nettype wire
